// File: rtl/sequence_player_if.sv
// Bundle of playback control and sequence-memory read signals for sequence_player.
interface sequence_player_if;
   logic       play;
   logic [1:0] speed;
   logic [4:0] seq_len;
   logic [1:0] rd_data;
   logic [3:0] rd_addr;
   logic       rd_en;
   logic [3:0] led;
   logic       busy;
   logic       done;

   // Controller and memory side: issues requests, returns memory data.
   modport master (
      output play, speed, seq_len, rd_data,
      input  rd_addr, rd_en, led, busy, done
   );

   // Player side.
   modport slave (
      input  play, speed, seq_len, rd_data,
      output rd_addr, rd_en, led, busy, done
   );
endinterface

// File: rtl/sequence_player.sv
// LED playback of the stored colour sequence: fetch item, show it for a
// speed-dependent on-time, blank for half that time, repeat, then pulse done.
module sequence_player #(
   parameter int unsigned TICK_DIV = 50000,
   parameter int unsigned ON_SLOW  = 800,
   parameter int unsigned ON_MED   = 500,
   parameter int unsigned ON_FAST  = 300,
   parameter int unsigned ON_TURBO = 150,
   parameter int unsigned MAX_LEN  = 16
) (
   input  logic             clk,
   input  logic             rst,
   sequence_player_if.slave bus
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned TW = $clog2(ON_SLOW + 1);

   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [4:0]    LEN_LIMIT = 5'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LATCH, S_ON, S_OFF, S_FINISH
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    idx_q,   idx_d;
   logic [4:0]    len_q,   len_d;
   logic [1:0]    spd_q,   spd_d;
   logic [1:0]    item_q,  item_d;
   logic [PW-1:0] pre_q,   pre_d;
   logic [TW-1:0] tick_q,  tick_d;

   logic [4:0]    len_clamped;
   logic [TW-1:0] on_t;
   logic [TW-1:0] off_t;
   logic          pre_last;
   logic          on_last;
   logic          off_last;
   logic          item_last;

   // Speed-dependent durations, length clamp and expiry flags.
   always_comb begin
      unique case (spd_q)
         2'd0:    on_t = TW'(ON_SLOW);
         2'd1:    on_t = TW'(ON_MED);
         2'd2:    on_t = TW'(ON_FAST);
         default: on_t = TW'(ON_TURBO);
      endcase
      off_t       = on_t >> 1;
      len_clamped = (bus.seq_len > LEN_LIMIT) ? LEN_LIMIT : bus.seq_len;
      pre_last    = (pre_q == PRE_LAST);
      on_last     = (tick_q == on_t - TW'(1));
      // A zero off-time still needs a terminating condition
      off_last    = (off_t == '0) || (tick_q == off_t - TW'(1));
      item_last   = ({1'b0, idx_q} == len_q - 5'd1);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         spd_q   <= '0;
         item_q  <= '0;
         pre_q   <= '0;
         tick_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         spd_q   <= spd_d;
         item_q  <= item_d;
         pre_q   <= pre_d;
         tick_q  <= tick_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      spd_d   = spd_q;
      item_d  = item_q;
      pre_d   = pre_q;
      tick_d  = tick_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.play) begin
               if (len_clamped != '0) begin
                  spd_d   = bus.speed;
                  len_d   = len_clamped;
                  idx_d   = '0;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_FINISH;
               end
            end
         end
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            item_d  = bus.rd_data;
            pre_d   = '0;
            tick_d  = '0;
            state_d = S_ON;
         end
         S_ON: begin
            if (pre_last) begin
               pre_d = '0;
               if (on_last) begin
                  tick_d  = '0;
                  state_d = S_OFF;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
         S_OFF: begin
            if (pre_last) begin
               pre_d = '0;
               if (off_last) begin
                  tick_d = '0;
                  if (item_last) begin
                     state_d = S_FINISH;
                  end else begin
                     idx_d   = idx_q + 4'd1;
                     state_d = S_FETCH;
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Moore outputs decoded from registered state.
   always_comb begin
      bus.led     = (state_q == S_ON) ? (4'd1 << item_q) : '0;
      bus.rd_en   = (state_q == S_FETCH);
      bus.rd_addr = idx_q;
      bus.busy    = (state_q != S_IDLE);
      bus.done    = (state_q == S_FINISH);
   end

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with TICK_DIV=4 and short on-times.
module tb_sequence_player;

   logic clk = 1'b0;
   logic rst;

   sequence_player_if bus();

   sequence_player #(
      .TICK_DIV (4),
      .ON_SLOW  (8),
      .ON_MED   (6),
      .ON_FAST  (4),
      .ON_TURBO (2),
      .MAX_LEN  (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Sequence memory: data valid the cycle after rd_en.
   logic [1:0] mem [16];
   always @(posedge clk or negedge rst) begin
      if (!rst)           bus.rd_data <= 2'd0;
      else if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
   end

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   logic [3:0] led_tr  [256];
   logic       rd_tr   [256];
   logic [3:0] addr_tr [256];
   logic       done_tr [256];
   logic       busy_tr [256];
   int n_rd, n_done, first_done, n_lit, max_addr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic start_play(input bit hold);
      bus.play = 1'b1;
      @(negedge clk);
      if (!hold) bus.play = 1'b0;
   endtask

   // Record n cycles of outputs; kind 1 pokes speed/play/seq_len, kind 2 drops play.
   task automatic capture(input int n, input int poke_at, input int kind);
      n_rd = 0; n_done = 0; first_done = -1; n_lit = 0; max_addr = 0;
      for (int c = 0; c < n; c++) begin
         led_tr[c]  = bus.led;
         rd_tr[c]   = bus.rd_en;
         addr_tr[c] = bus.rd_addr;
         done_tr[c] = bus.done;
         busy_tr[c] = bus.busy;
         if (bus.rd_en) begin
            n_rd++;
            if (int'(bus.rd_addr) > max_addr) max_addr = int'(bus.rd_addr);
         end
         if (bus.done) begin
            n_done++;
            if (first_done < 0) first_done = c;
         end
         if (bus.led != 4'd0) n_lit++;
         if (c == poke_at) begin
            if (kind == 1) begin
               bus.speed   = 2'd0;
               bus.play    = 1'b1;
               bus.seq_len = 5'd9;
            end else if (kind == 2) begin
               bus.play = 1'b0;
            end
         end
         if (kind == 1 && c == poke_at + 1) bus.play = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      rst         = 1'b0;
      bus.play    = 1'b0;
      bus.speed   = 2'd0;
      bus.seq_len = 5'd0;
      for (int i = 0; i < 16; i++) mem[i] = 2'd0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_led",   bus.led,     4'd0);
      check("rst_busy",  bus.busy,    1'b0);
      check("rst_done",  bus.done,    1'b0);
      check("rst_rd_en", bus.rd_en,   1'b0);
      check("rst_addr",  bus.rd_addr, 4'd0);
      rst = 1'b1;
      @(negedge clk);

      // Three items at speed 0: 50-cycle items, done 150 cycles after accept
      mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
      bus.seq_len = 5'd3; bus.speed = 2'd0;
      start_play(1'b0);
      capture(160, -1, 0);
      check("t1_rd0",     rd_tr[0],   1'b1);
      check("t1_addr0",   addr_tr[0], 4'd0);
      check("t1_addr1",   addr_tr[50], 4'd1);
      check("t1_addr2",   addr_tr[100], 4'd2);
      check("t1_latch",   rd_tr[1],   1'b0);
      check("t1_led1",    led_tr[1],  4'd0);
      check("t1_on_beg",  led_tr[2],  4'b0100);
      check("t1_on_end",  led_tr[33], 4'b0100);
      check("t1_off_beg", led_tr[34], 4'd0);
      check("t1_off_end", led_tr[49], 4'd0);
      check("t1_item1a",  led_tr[52], 4'b0001);
      check("t1_item1b",  led_tr[83], 4'b0001);
      check("t1_item2",   led_tr[102], 4'b1000);
      check("t1_lit",     n_lit,      96);
      check("t1_nrd",     n_rd,       3);
      check("t1_done_at", first_done, 150);
      check("t1_ndone",   n_done,     1);
      check("t1_idle",    busy_tr[151], 1'b0);

      // Zero length: immediate done, no reads, no LEDs
      bus.seq_len = 5'd0; bus.speed = 2'd1;
      start_play(1'b0);
      capture(6, -1, 0);
      check("t2_done_at", first_done, 0);
      check("t2_ndone",   n_done,     1);
      check("t2_nrd",     n_rd,       0);
      check("t2_lit",     n_lit,      0);
      check("t2_busy0",   busy_tr[0], 1'b1);
      check("t2_busy1",   busy_tr[1], 1'b0);

      // Length 20 clamps to 16 at speed 3: 14-cycle items
      for (int i = 0; i < 16; i++) mem[i] = 2'(i % 4);
      bus.seq_len = 5'd20; bus.speed = 2'd3;
      start_play(1'b0);
      capture(232, -1, 0);
      check("t3_nrd",     n_rd,       16);
      check("t3_maxaddr", max_addr,   15);
      check("t3_addr15",  addr_tr[210], 4'd15);
      check("t3_done_at", first_done, 224);
      check("t3_ndone",   n_done,     1);
      check("t3_lit",     n_lit,      128);
      check("t3_k5_on",   led_tr[72], 4'b0010);
      check("t3_k5_onz",  led_tr[79], 4'b0010);
      check("t3_k5_off",  led_tr[80], 4'd0);
      check("t3_k5_offz", led_tr[83], 4'd0);
      check("t3_k6_rd",   rd_tr[84],  1'b1);
      check("t3_k15_on",  led_tr[212], 4'b1000);

      // Speed/length/play changes while busy are ignored
      mem[0] = 2'd1; mem[1] = 2'd2;
      bus.seq_len = 5'd2; bus.speed = 2'd3;
      start_play(1'b0);
      capture(40, 5, 1);
      check("t4_done_at", first_done, 28);
      check("t4_ndone",   n_done,     1);
      check("t4_nrd",     n_rd,       2);
      check("t4_lit",     n_lit,      16);
      check("t4_on_end",  led_tr[9],  4'b0010);
      check("t4_off",     led_tr[10], 4'd0);
      check("t4_item1",   led_tr[16], 4'b0100);
      check("t4_item1o",  led_tr[24], 4'd0);
      check("t4_idle",    busy_tr[30], 1'b0);

      // Asynchronous reset during ON of item 1
      mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
      bus.seq_len = 5'd3; bus.speed = 2'd0;
      start_play(1'b0);
      repeat (60) @(negedge clk);
      check("t5_pre_led",  bus.led,  4'b0001);
      check("t5_pre_busy", bus.busy, 1'b1);
      rst = 1'b0;
      #1;
      check("t5_led",   bus.led,     4'd0);
      check("t5_busy",  bus.busy,    1'b0);
      check("t5_rd_en", bus.rd_en,   1'b0);
      check("t5_done",  bus.done,    1'b0);
      check("t5_addr",  bus.rd_addr, 4'd0);
      @(negedge clk);
      rst = 1'b1;
      capture(60, -1, 0);
      check("t5_no_done", n_done, 0);
      check("t5_no_rd",   n_rd,   0);
      check("t5_still",   busy_tr[59], 1'b0);
      bus.seq_len = 5'd1;
      start_play(1'b0);
      capture(60, -1, 0);
      check("t5b_rd0",     rd_tr[0],   1'b1);
      check("t5b_addr0",   addr_tr[0], 4'd0);
      check("t5b_led",     led_tr[2],  4'b0100);
      check("t5b_done_at", first_done, 50);
      check("t5b_ndone",   n_done,     1);
      check("t5b_nrd",     n_rd,       1);

      // play held high: back-to-back playbacks, refetch 2 cycles after done
      mem[0] = 2'd3;
      bus.seq_len = 5'd1; bus.speed = 2'd2;
      start_play(1'b1);
      capture(70, 54, 2);
      check("t6_done_at", first_done,  26);
      check("t6_ndone",   n_done,      2);
      check("t6_done2",   done_tr[54], 1'b1);
      check("t6_refetch", rd_tr[28],   1'b1);
      check("t6_addr",    addr_tr[28], 4'd0);
      check("t6_gap",     rd_tr[27],   1'b0);
      check("t6_nrd",     n_rd,        2);
      check("t6_led",     led_tr[30],  4'b1000);
      check("t6_lit",     n_lit,       32);
      check("t6_idle",    busy_tr[56], 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
